// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode decode, byte geometry and link FSM states.
package spi_pkg;

    localparam int c_BITS_PER_BYTE = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_t;

    // Clock polarity: modes 2 and 3 idle SCLK high.
    function automatic logic cpol(input int mode);
        return (mode >= 32'sd2);
    endfunction

    // Clock phase: odd modes sample on the trailing edge.
    function automatic logic cpha(input int mode);
        return ((mode % 32'sd2) == 32'sd1);
    endfunction

endpackage

// File: rtl/spi_input_sync.sv
// Brings one asynchronous pin into the i_CLK domain and flags its edges.
module spi_input_sync #(
    parameter logic c_RESET_VAL = 1'b0
) (
    input  logic i_CLK,
    input  logic i_RESET_n,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic hist_q;

    // Two-stage synchronizer followed by a history flop for edge detection.
    always_ff @(posedge i_CLK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            meta_q <= c_RESET_VAL;
            sync_q <= c_RESET_VAL;
            hist_q <= c_RESET_VAL;
        end else begin
            meta_q <= pin_i;
            sync_q <= meta_q;
            hist_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = sync_q & ~hist_q;
    assign fall_o  = ~sync_q & hist_q;

endmodule

// File: rtl/spi_slave.sv
// SPI responder: oversampled pins, byte-wide TX holding register and RX output.
module spi_slave
    import spi_pkg::*;
#(
    parameter int         c_SPI_MODE  = 3,
    parameter logic [7:0] c_IDLE_BYTE = 8'hFF
) (
    input  logic       i_CLK,
    input  logic       i_RESET_n,
    input  logic [7:0] i_TX_BYTE,
    input  logic       i_TX_DV,
    output logic       o_TX_READY,
    output logic       o_TX_UNDERRUN,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_BYTE,
    input  logic       i_SPI_CLK,
    input  logic       i_SPI_CS_n,
    input  logic       i_SPI_MOSI,
    output logic       o_SPI_MISO,
    output logic       o_SPI_MISO_EN
);

    localparam logic c_CPOL = cpol(c_SPI_MODE);
    localparam logic c_CPHA = cpha(c_SPI_MODE);
    localparam int   c_CNT_W = $clog2(c_BITS_PER_BYTE);
    localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(c_BITS_PER_BYTE - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ZERO = {c_CNT_W{1'b0}};

    logic sclk_level_s, sclk_rise_s, sclk_fall_s;
    logic cs_level_s, cs_rise_s, cs_fall_s;
    logic mosi_level_s, mosi_rise_s, mosi_fall_s;
    logic leading_s, trailing_s, sample_s, shift_s, load_s;
    logic unused_s;

    spi_state_t        state_q, state_d;
    logic [c_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]        rx_shift_q, rx_shift_d;
    logic [7:0]        tx_shift_q, tx_shift_d;
    logic [7:0]        hold_q, hold_d;
    logic              hold_empty_q, hold_empty_d;
    logic [7:0]        rx_byte_q, rx_byte_d;
    logic              rx_dv_q, rx_dv_d;
    logic              underrun_q, underrun_d;
    logic              miso_q, miso_d;
    logic              miso_en_q, miso_en_d;

    spi_input_sync #(.c_RESET_VAL(c_CPOL)) u_sclk_sync (
        .i_CLK(i_CLK), .i_RESET_n(i_RESET_n), .pin_i(i_SPI_CLK),
        .level_o(sclk_level_s), .rise_o(sclk_rise_s), .fall_o(sclk_fall_s)
    );

    spi_input_sync #(.c_RESET_VAL(1'b1)) u_cs_sync (
        .i_CLK(i_CLK), .i_RESET_n(i_RESET_n), .pin_i(i_SPI_CS_n),
        .level_o(cs_level_s), .rise_o(cs_rise_s), .fall_o(cs_fall_s)
    );

    spi_input_sync #(.c_RESET_VAL(1'b0)) u_mosi_sync (
        .i_CLK(i_CLK), .i_RESET_n(i_RESET_n), .pin_i(i_SPI_MOSI),
        .level_o(mosi_level_s), .rise_o(mosi_rise_s), .fall_o(mosi_fall_s)
    );

    // Only the MOSI level and the CS/SCLK transitions drive the datapath.
    assign unused_s = ^{sclk_level_s, cs_level_s, mosi_rise_s, mosi_fall_s};

    // Leading edge leaves the idle level; CPHA picks which edge samples.
    assign leading_s  = c_CPOL ? sclk_fall_s : sclk_rise_s;
    assign trailing_s = c_CPOL ? sclk_rise_s : sclk_fall_s;
    assign sample_s   = c_CPHA ? trailing_s : leading_s;
    assign shift_s    = c_CPHA ? leading_s  : trailing_s;

    // Next-state logic for the link FSM, shift registers and fabric handshakes.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        rx_shift_d   = rx_shift_q;
        tx_shift_d   = tx_shift_q;
        hold_d       = hold_q;
        hold_empty_d = hold_empty_q;
        rx_byte_d    = rx_byte_q;
        rx_dv_d      = 1'b0;
        underrun_d   = 1'b0;
        miso_d       = miso_q;
        miso_en_d    = miso_en_q;
        load_s       = 1'b0;

        if (i_TX_DV && hold_empty_q) begin
            hold_d       = i_TX_BYTE;
            hold_empty_d = 1'b0;
        end else begin
            hold_d = hold_q;
        end

        case (state_q)
            IDLE: begin
                if (cs_fall_s) begin
                    state_d    = ACTIVE;
                    miso_en_d  = 1'b1;
                    bit_cnt_d  = c_CNT_ZERO;
                    rx_shift_d = 8'h00;
                    load_s     = ~c_CPHA;
                end else begin
                    miso_en_d = 1'b0;
                end
            end
            ACTIVE: begin
                if (cs_rise_s) begin
                    // Frame aborted or finished: drop any partial byte.
                    state_d    = IDLE;
                    miso_en_d  = 1'b0;
                    bit_cnt_d  = c_CNT_ZERO;
                    rx_shift_d = 8'h00;
                end else if (sample_s) begin
                    rx_shift_d = {rx_shift_q[6:0], mosi_level_s};
                    if (bit_cnt_q == c_LAST_BIT) begin
                        bit_cnt_d = c_CNT_ZERO;
                        rx_byte_d = {rx_shift_q[6:0], mosi_level_s};
                        rx_dv_d   = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (shift_s) begin
                    // A zero count at a shift edge marks a byte boundary.
                    if (bit_cnt_q == c_CNT_ZERO) begin
                        load_s = 1'b1;
                    end else begin
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                        miso_d     = tx_shift_q[6];
                    end
                end else begin
                    state_d = ACTIVE;
                end
            end
            default: begin
                state_d   = IDLE;
                miso_en_d = 1'b0;
            end
        endcase

        if (load_s) begin
            if (!hold_empty_q) begin
                tx_shift_d   = hold_q;
                hold_empty_d = 1'b1;
            end else if (i_TX_DV) begin
                // Byte arriving on the load cycle bypasses the holding register.
                tx_shift_d   = i_TX_BYTE;
                hold_empty_d = 1'b1;
            end else begin
                tx_shift_d = c_IDLE_BYTE;
                underrun_d = 1'b1;
            end
            miso_d = tx_shift_d[7];
        end else begin
            underrun_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge i_CLK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            state_q      <= IDLE;
            bit_cnt_q    <= c_CNT_ZERO;
            rx_shift_q   <= 8'h00;
            tx_shift_q   <= 8'h00;
            hold_q       <= 8'h00;
            hold_empty_q <= 1'b1;
            rx_byte_q    <= 8'h00;
            rx_dv_q      <= 1'b0;
            underrun_q   <= 1'b0;
            miso_q       <= 1'b0;
            miso_en_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_shift_q   <= rx_shift_d;
            tx_shift_q   <= tx_shift_d;
            hold_q       <= hold_d;
            hold_empty_q <= hold_empty_d;
            rx_byte_q    <= rx_byte_d;
            rx_dv_q      <= rx_dv_d;
            underrun_q   <= underrun_d;
            miso_q       <= miso_d;
            miso_en_q    <= miso_en_d;
        end
    end

    assign o_TX_READY    = hold_empty_q;
    assign o_TX_UNDERRUN = underrun_q;
    assign o_RX_DV       = rx_dv_q;
    assign o_RX_BYTE     = rx_byte_q;
    assign o_SPI_MISO    = miso_q;
    assign o_SPI_MISO_EN = miso_en_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: one instance per SPI mode, scoreboarded RX bytes.
module tb_spi_slave;

    localparam int HP = 8;  // SCLK half period in i_CLK cycles

    logic clk = 1'b0;
    logic rst_n;

    logic [7:0] tx_byte  [4] = '{default: 8'h00};
    logic       tx_dv    [4] = '{default: 1'b0};
    logic       sclk     [4];
    logic       cs_n     [4];
    logic       mosi     [4];
    logic       tx_ready [4];
    logic       underrun [4];
    logic       rx_dv    [4];
    logic [7:0] rx_byte  [4];
    logic       miso     [4];
    logic       miso_en  [4];

    int n_checks = 0;
    int n_fail   = 0;
    int rx_cnt  [4] = '{default: 0};
    int und_cnt [4] = '{default: 0};

    logic [7:0] rx_exp [$];
    logic [7:0] txq [$];
    int   cur_m = 3;
    logic refill_en = 1'b0;

    always #10 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave #(.c_SPI_MODE(g), .c_IDLE_BYTE(8'hFF)) u_dut (
            .i_CLK(clk), .i_RESET_n(rst_n),
            .i_TX_BYTE(tx_byte[g]), .i_TX_DV(tx_dv[g]), .o_TX_READY(tx_ready[g]),
            .o_TX_UNDERRUN(underrun[g]), .o_RX_DV(rx_dv[g]), .o_RX_BYTE(rx_byte[g]),
            .i_SPI_CLK(sclk[g]), .i_SPI_CS_n(cs_n[g]), .i_SPI_MOSI(mosi[g]),
            .o_SPI_MISO(miso[g]), .o_SPI_MISO_EN(miso_en[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Feed the TX queue to the active instance whenever it is ready.
    always @(negedge clk) begin
        for (int m = 0; m < 4; m++) tx_dv[m] = 1'b0;
        if (refill_en && tx_ready[cur_m] && txq.size() > 0) begin
            tx_byte[cur_m] = txq.pop_front();
            tx_dv[cur_m]   = 1'b1;
        end
    end

    // Scoreboard: every RX_DV pops one expected byte; count underrun pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int m = 0; m < 4; m++) begin
                if (rx_dv[m]) begin
                    rx_cnt[m]++;
                    check("rx_pending", 32'(rx_exp.size() > 0), 32'd1);
                    if (rx_exp.size() > 0) check("rx_byte", 32'(rx_byte[m]), 32'(rx_exp.pop_front()));
                end
                if (underrun[m]) und_cnt[m]++;
            end
        end
    end

    task automatic cs_low(input int m);
        cs_n[m] = 1'b0;
        wait_clk(HP);
    endtask

    task automatic cs_high(input int m);
        wait_clk(HP);
        cs_n[m] = 1'b1;
        wait_clk(HP);
    endtask

    // Master side of one byte (or nbits of it), MSb first; returns MISO bits seen.
    task automatic xfer(input int m, input logic [7:0] b, input int nbits, output logic [7:0] got);
        logic pol;
        logic pha;
        pol = (m >= 2);
        pha = (m % 2 == 1);
        got = 8'h00;
        if (nbits == 8) rx_exp.push_back(b);
        for (int i = 7; i > 7 - nbits; i--) begin
            if (!pha) begin
                mosi[m] = b[i];
                wait_clk(HP);
                got[i]  = miso[m];
                sclk[m] = ~pol;
                wait_clk(HP);
                sclk[m] = pol;
            end else begin
                sclk[m] = ~pol;
                mosi[m] = b[i];
                wait_clk(HP);
                got[i]  = miso[m];
                sclk[m] = pol;
                wait_clk(HP);
            end
        end
    endtask

    initial begin
        logic [7:0] got;
        int rx0;
        int u0;
        rst_n = 1'b0;
        for (int m = 0; m < 4; m++) begin
            sclk[m] = (m >= 2);
            cs_n[m] = 1'b1;
            mosi[m] = 1'b0;
        end
        wait_clk(4);
        rst_n = 1'b1;
        wait_clk(4);

        // Reset state
        check("rst_ready", 32'(tx_ready[3]), 32'd1);
        check("rst_miso_en", 32'(miso_en[3]), 32'd0);
        check("rst_miso", 32'(miso[0]), 32'd0);
        check("rst_rx_byte", 32'(rx_byte[3]), 32'd0);

        // T1: mode 3, TX A5, master sends 3C
        cur_m = 3; refill_en = 1'b1;
        txq.push_back(8'hA5);
        wait_clk(4);
        check("t1_ready_low", 32'(tx_ready[3]), 32'd0);
        rx0 = rx_cnt[3]; u0 = und_cnt[3];
        cs_low(3);
        xfer(3, 8'h3C, 8, got);
        check("t1_miso", 32'(got), 32'hA5);
        cs_high(3);
        check("t1_ready_back", 32'(tx_ready[3]), 32'd1);
        check("t1_rx_count", 32'(rx_cnt[3] - rx0), 32'd1);
        check("t1_no_underrun", 32'(und_cnt[3] - u0), 32'd0);

        // T2: mode 0, TX 81, master sends C3
        cur_m = 0;
        txq.push_back(8'h81);
        wait_clk(4);
        cs_low(0);
        check("t2_miso_en", 32'(miso_en[0]), 32'd1);
        check("t2_miso_first", 32'(miso[0]), 32'd1);
        xfer(0, 8'hC3, 8, got);
        check("t2_miso", 32'(got), 32'h81);
        cs_high(0);
        check("t2_miso_en_off", 32'(miso_en[0]), 32'd0);

        // T3: modes 1 and 2, three back-to-back bytes with TX refill
        for (int m = 1; m <= 2; m++) begin
            cur_m = m;
            txq.push_back(8'h11); txq.push_back(8'h22);
            txq.push_back(8'h33); txq.push_back(8'h44);
            wait_clk(4);
            rx0 = rx_cnt[m]; u0 = und_cnt[m];
            cs_low(m);
            xfer(m, 8'h01, 8, got); check("t3_miso0", 32'(got), 32'h11);
            xfer(m, 8'h02, 8, got); check("t3_miso1", 32'(got), 32'h22);
            xfer(m, 8'h03, 8, got); check("t3_miso2", 32'(got), 32'h33);
            cs_high(m);
            check("t3_rx_count", 32'(rx_cnt[m] - rx0), 32'd3);
            check("t3_no_underrun", 32'(und_cnt[m] - u0), 32'd0);
            txq.delete();
        end

        // T4: mode 3, nothing queued -> idle bytes and one underrun per byte
        cur_m = 3;
        rx0 = rx_cnt[3]; u0 = und_cnt[3];
        cs_low(3);
        xfer(3, 8'h12, 8, got); check("t4_miso0", 32'(got), 32'hFF);
        xfer(3, 8'h34, 8, got); check("t4_miso1", 32'(got), 32'hFF);
        cs_high(3);
        check("t4_underruns", 32'(und_cnt[3] - u0), 32'd2);
        check("t4_rx_count", 32'(rx_cnt[3] - rx0), 32'd2);

        // T5: partial 5-bit frame then full 5A
        rx0 = rx_cnt[3];
        cs_low(3);
        xfer(3, 8'hE7, 5, got);
        cs_high(3);
        check("t5_no_partial_dv", 32'(rx_cnt[3] - rx0), 32'd0);
        cs_low(3);
        xfer(3, 8'h5A, 8, got);
        cs_high(3);
        check("t5_rx_count", 32'(rx_cnt[3] - rx0), 32'd1);
        check("t5_rx_hold", 32'(rx_byte[3]), 32'h5A);

        // T6: reset in the middle of a byte, then a clean frame
        txq.push_back(8'h69);
        wait_clk(4);
        cs_low(3);
        xfer(3, 8'hF0, 4, got);
        check("t6_miso_en_pre", 32'(miso_en[3]), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("t6_rx_byte", 32'(rx_byte[3]), 32'd0);
        check("t6_miso_en", 32'(miso_en[3]), 32'd0);
        check("t6_miso", 32'(miso[3]), 32'd0);
        check("t6_ready", 32'(tx_ready[3]), 32'd1);
        check("t6_rx_dv", 32'(rx_dv[3]), 32'd0);
        check("t6_underrun", 32'(underrun[3]), 32'd0);
        cs_n[3] = 1'b1;
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(4);
        txq.push_back(8'hC6);
        wait_clk(4);
        rx0 = rx_cnt[3];
        cs_low(3);
        xfer(3, 8'h96, 8, got);
        check("t6_miso_after", 32'(got), 32'hC6);
        cs_high(3);
        check("t6_rx_count", 32'(rx_cnt[3] - rx0), 32'd1);

        check("rx_drained", 32'(rx_exp.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
